// File: rtl/mem_access_stage_pkg.sv
// Shared memory-access encodings: access size, i_mem / i_wb bit positions,
// and the lane helpers used by the memory stage.
package mem_access_stage_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } mem_size_e;

  localparam int MEM_READ_BIT     = 4;
  localparam int MEM_WRITE_BIT    = 3;
  localparam int MEM_UNSIGNED_BIT = 2;
  localparam int MEM_SIZE_MSB     = 1;
  localparam int MEM_SIZE_LSB     = 0;

  localparam int WB_REGWRITE_BIT  = 1;
  localparam int WB_MEMTOREG_BIT  = 0;

  // The reserved size behaves like a word everywhere.
  function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] offset);
    case (size)
      SIZE_BYTE: is_misaligned = 1'b0;
      SIZE_HALF: is_misaligned = offset[0];
      default:   is_misaligned = (offset != 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input mem_size_e size, input logic [1:0] offset);
    case (size)
      SIZE_BYTE: lane_mask = 4'b0001 << offset;
      SIZE_HALF: lane_mask = 4'b0011 << offset;
      default:   lane_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_stage_data_mem.sv
// Word-organised data memory with per-byte write enables; synchronous
// read-before-write so a simultaneous read returns the pre-write word.
module data_mem #(
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk_i,
  input  logic                 re_i,
  input  logic [3:0]           we_i,
  input  logic [ADDR_BITS-1:0] addr_i,
  input  logic [31:0]          wdata_i,
  output logic [31:0]          rdata_o
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (re_i) begin
      rdata_o <= mem_q[addr_i];
    end
    for (int b = 0; b < 4; b++) begin
      if (we_i[b]) begin
        mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// Pipeline memory stage: EX/MEM register, byte/half/word access to the data
// memory, and a MEM/WB register with the load formatter on its output.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int MEM_ADDR_BITS = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic [DATA_WIDTH-1:0] i_aluresult,
  input  logic [DATA_WIDTH-1:0] i_regB,
  input  logic [4:0]            i_rd_rt,
  input  logic [4:0]            i_mem,
  input  logic [1:0]            i_wb,
  input  logic                  i_stall,
  input  logic                  i_flush,
  output logic [DATA_WIDTH-1:0] o_readdata,
  output logic [DATA_WIDTH-1:0] o_aluresult,
  output logic [4:0]            o_rd_rt,
  output logic [1:0]            o_wb,
  output logic                  o_misaligned
);

  // EX/MEM
  logic [DATA_WIDTH-1:0] ex_alu_q, ex_regb_q;
  logic [4:0]            ex_rd_q, ex_mem_q;
  logic [1:0]            ex_wb_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ex_alu_q  <= '0;
      ex_regb_q <= '0;
      ex_rd_q   <= '0;
      ex_mem_q  <= '0;
      ex_wb_q   <= '0;
    end else if (i_flush) begin
      ex_alu_q  <= i_aluresult;
      ex_regb_q <= i_regB;
      ex_rd_q   <= i_rd_rt;
      ex_mem_q  <= '0;
      ex_wb_q   <= '0;
    end else if (!i_stall) begin
      ex_alu_q  <= i_aluresult;
      ex_regb_q <= i_regB;
      ex_rd_q   <= i_rd_rt;
      ex_mem_q  <= i_mem;
      ex_wb_q   <= i_wb;
    end
  end

  // Access decode for the instruction sitting in EX/MEM
  logic [1:0]             ex_off;
  mem_size_e              ex_size;
  logic                   ex_read, ex_write, ex_mis, store_en;
  logic [3:0]             mem_we;
  logic [31:0]            mem_wdata, mem_rdata;
  logic [MEM_ADDR_BITS-1:0] mem_addr;
  logic                   mem_re;

  assign ex_off   = ex_alu_q[1:0];
  assign ex_size  = mem_size_e'(ex_mem_q[MEM_SIZE_MSB:MEM_SIZE_LSB]);
  assign ex_read  = ex_mem_q[MEM_READ_BIT];
  assign ex_write = ex_mem_q[MEM_WRITE_BIT];
  assign ex_mis   = (ex_read | ex_write) & is_misaligned(ex_size, ex_off);
  assign store_en = ex_write & ~ex_mis & ~i_stall;
  assign mem_we   = store_en ? lane_mask(ex_size, ex_off) : 4'b0000;
  assign mem_addr = ex_alu_q[MEM_ADDR_BITS+1:2];
  assign mem_re   = ~i_stall;

  // Replicating the store data lets the lane mask alone pick the target bytes.
  always_comb begin
    mem_wdata = ex_regb_q;
    case (ex_size)
      SIZE_BYTE: mem_wdata = {4{ex_regb_q[7:0]}};
      SIZE_HALF: mem_wdata = {2{ex_regb_q[15:0]}};
      default:   mem_wdata = ex_regb_q;
    endcase
  end

  data_mem #(
    .ADDR_BITS(MEM_ADDR_BITS)
  ) u_data_mem (
    .clk_i   (i_clk),
    .re_i    (mem_re),
    .we_i    (mem_we),
    .addr_i  (mem_addr),
    .wdata_i (mem_wdata),
    .rdata_o (mem_rdata)
  );

  // MEM/WB; the read word itself lives in the memory's output register.
  logic [DATA_WIDTH-1:0] wb_alu_q;
  logic [4:0]            wb_rd_q;
  logic [1:0]            wb_wb_q, wb_off_q;
  logic                  wb_mis_q, wb_read_q, wb_uns_q;
  mem_size_e             wb_size_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wb_alu_q  <= '0;
      wb_rd_q   <= '0;
      wb_wb_q   <= '0;
      wb_off_q  <= '0;
      wb_mis_q  <= 1'b0;
      wb_read_q <= 1'b0;
      wb_uns_q  <= 1'b0;
      wb_size_q <= SIZE_BYTE;
    end else if (!i_stall) begin
      wb_alu_q  <= ex_alu_q;
      wb_rd_q   <= ex_rd_q;
      wb_wb_q   <= {ex_wb_q[WB_REGWRITE_BIT] & ~ex_mis, ex_wb_q[WB_MEMTOREG_BIT]};
      wb_off_q  <= ex_off;
      wb_mis_q  <= ex_mis;
      wb_read_q <= ex_read;
      wb_uns_q  <= ex_mem_q[MEM_UNSIGNED_BIT];
      wb_size_q <= ex_size;
    end
  end

  logic [31:0] lane_word;
  logic [31:0] load_data;

  always_comb begin
    lane_word = mem_rdata >> {wb_off_q, 3'b000};
    load_data = '0;
    if (wb_read_q && !wb_mis_q) begin
      case (wb_size_q)
        SIZE_BYTE: load_data = wb_uns_q ? {24'b0, lane_word[7:0]}
                                        : {{24{lane_word[7]}}, lane_word[7:0]};
        SIZE_HALF: load_data = wb_uns_q ? {16'b0, lane_word[15:0]}
                                        : {{16{lane_word[15]}}, lane_word[15:0]};
        default:   load_data = lane_word;
      endcase
    end
  end

  assign o_readdata   = load_data;
  assign o_aluresult  = wb_alu_q;
  assign o_rd_rt      = wb_rd_q;
  assign o_wb         = wb_wb_q;
  assign o_misaligned = wb_mis_q;

endmodule
